// File: rtl/int_bit_manip16_pkg.sv
// Shared constants and types for the 64-bit bit-manipulation unit.
// Operation encoding, data/index widths and the packed request word.
package int_bit_manip16_pkg;

  localparam int DATA_W = 64;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 7;  // counts span 0..64

  typedef enum logic [2:0] {
    OP_CLR  = 3'd0,
    OP_SET  = 3'd1,
    OP_TST  = 3'd2,
    OP_TGL  = 3'd3,
    OP_POPC = 3'd4,
    OP_CLZ  = 3'd5,
    OP_CTZ  = 3'd6,
    OP_FFS  = 3'd7
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] a;
    logic [IDX_W-1:0]  idx;
  } req_t;

  function automatic logic [DATA_W-1:0] cnt_ext(input logic [CNT_W-1:0] c);
    return {{(DATA_W-CNT_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/int_bit_count.sv
// Combinational popcount / leading-zero / trailing-zero counter over 64 bits.
// Zero latency, no flow control; an all-zero input yields clz = ctz = 64.
module int_bit_count
  import int_bit_manip16_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  output logic [CNT_W-1:0]  popc,
  output logic [CNT_W-1:0]  clz,
  output logic [CNT_W-1:0]  ctz,
  output logic              zero
);

  always_comb begin
    popc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      popc = popc + CNT_W'(a[i]);
    end
  end

  // Ascending scan: the highest set bit is the last one to overwrite clz.
  always_comb begin
    clz = CNT_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (a[i]) clz = CNT_W'(DATA_W - 1 - i);
    end
  end

  always_comb begin
    ctz = CNT_W'(DATA_W);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (a[i]) ctz = CNT_W'(i);
    end
  end

  assign zero = ~|a;

endmodule

// File: rtl/int_bit_manip16.sv
// Registered 64-bit bit set/clear/test/toggle and popcount/clz/ctz/ffs unit.
// One-cycle latency, accepts an operation every clock; no backpressure.
module int_bit_manip16
  import int_bit_manip16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        operation,
  input  logic [DATA_W-1:0] opa_bit_manip,
  input  logic [DATA_W-1:0] opb_bit_manip,
  output logic [DATA_W-1:0] out_bit_manip
);

  req_t              req;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] res;
  logic [CNT_W-1:0]  popc, clz, ctz;
  logic              zero;
  logic              unused_opb_hi;

  assign req.op  = op_e'(operation);
  assign req.a   = opa_bit_manip;
  assign req.idx = opb_bit_manip[IDX_W-1:0];

  // Only the index field of B is architecturally visible.
  assign unused_opb_hi = ^opb_bit_manip[DATA_W-1:IDX_W];

  assign mask = DATA_W'(1) << req.idx;

  int_bit_count u_count (
    .a    (req.a),
    .popc (popc),
    .clz  (clz),
    .ctz  (ctz),
    .zero (zero)
  );

  always_comb begin
    res = '0;
    case (req.op)
      OP_CLR:  res = req.a & ~mask;
      OP_SET:  res = req.a | mask;
      OP_TST:  res = {{(DATA_W-1){1'b0}}, req.a[req.idx]};
      OP_TGL:  res = req.a ^ mask;
      OP_POPC: res = cnt_ext(popc);
      OP_CLZ:  res = cnt_ext(clz);
      OP_CTZ:  res = cnt_ext(ctz);
      OP_FFS:  res = zero ? '0 : cnt_ext(ctz + CNT_W'(1));
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_bit_manip <= '0;
    else        out_bit_manip <= res;
  end

endmodule

// File: tb/tb_int_bit_manip16.sv
// Directed table-driven bench for int_bit_manip16 plus reset and back-to-back sequences.
module tb_int_bit_manip16;
  import int_bit_manip16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  operation = 3'd0;
  logic [63:0] opa = '0;
  logic [63:0] opb = '0;
  logic [63:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];
  vec_t b2b[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] PAT  = 64'h0000_0000_00F0_0F00;

  int_bit_manip16 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .operation     (operation),
    .opa_bit_manip (opa),
    .opb_bit_manip (opb),
    .out_bit_manip (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(inout vec_t q[$], input logic [2:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    q.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    operation = v.op;
    opa       = v.a;
    opb       = v.b;
  endtask

  initial begin
    // CLR
    add(vecs, 3'd0, 64'd18, 64'd2, 64'd18);
    add(vecs, 3'd0, 64'd16, 64'd5, 64'd16);
    add(vecs, 3'd0, 64'd16, 64'd4, 64'd0);
    add(vecs, 3'd0, ONES, 64'd63, 64'h7FFF_FFFF_FFFF_FFFF);
    add(vecs, 3'd0, ONES, 64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFFE);
    // SET / TGL
    add(vecs, 3'd1, 64'd0, 64'd2, 64'd4);
    add(vecs, 3'd1, 64'd2, 64'd5, 64'd34);
    add(vecs, 3'd3, 64'd18, 64'd1, 64'd16);
    add(vecs, 3'd1, 64'd0, 64'h100, 64'd1);
    add(vecs, 3'd3, ONES, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    add(vecs, 3'd3, 64'd0, 64'd63, MSB);
    // TST
    add(vecs, 3'd2, 64'd18, 64'd2, 64'd0);
    add(vecs, 3'd2, 64'd18, 64'd4, 64'd1);
    add(vecs, 3'd2, 64'd18, 64'd5, 64'd0);
    add(vecs, 3'd2, MSB, 64'd63, 64'd1);
    add(vecs, 3'd2, MSB, 64'hFFFF_FFFF_FFFF_FF80, 64'd0);
    // Counts
    add(vecs, 3'd4, 64'd18, 64'd0, 64'd2);
    add(vecs, 3'd4, ONES, 64'd0, 64'd64);
    add(vecs, 3'd4, 64'hF0, ONES, 64'd4);
    add(vecs, 3'd5, 64'd18, 64'd0, 64'd59);
    add(vecs, 3'd5, 64'd0, 64'd0, 64'd64);
    add(vecs, 3'd5, MSB, 64'd0, 64'd0);
    add(vecs, 3'd5, 64'd1, 64'd0, 64'd63);
    add(vecs, 3'd6, 64'd18, 64'd0, 64'd1);
    add(vecs, 3'd6, 64'd0, 64'd0, 64'd64);
    add(vecs, 3'd6, MSB, 64'd0, 64'd63);
    add(vecs, 3'd7, 64'd18, 64'd0, 64'd2);
    add(vecs, 3'd7, 64'd0, 64'd0, 64'd0);
    add(vecs, 3'd7, MSB, 64'd0, 64'd64);
    add(vecs, 3'd7, 64'd1, ONES, 64'd1);
    // Back-to-back walk through all eight operations
    add(b2b, 3'd0, PAT, 64'd9,  64'h0000_0000_00F0_0D00);
    add(b2b, 3'd1, PAT, 64'd12, 64'h0000_0000_00F0_1F00);
    add(b2b, 3'd2, PAT, 64'd20, 64'd1);
    add(b2b, 3'd3, PAT, 64'd63, 64'h8000_0000_00F0_0F00);
    add(b2b, 3'd4, PAT, 64'd0,  64'd8);
    add(b2b, 3'd5, PAT, 64'd0,  64'd40);
    add(b2b, 3'd6, PAT, 64'd0,  64'd8);
    add(b2b, 3'd7, PAT, 64'd0,  64'd9);

    // Reset: output held at zero while rst_n is low, first result after release
    operation = 3'd1; opa = 64'd0; opb = 64'd2;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", out, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check("reset_release_first", out, 64'd4);

    // Asynchronous assertion mid-cycle clears without a clock edge
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("reset_async_clear", out, 64'd0);
    @(posedge clk); #1 check("reset_async_held", out, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check("reset_async_release", out, 64'd4);

    // Directed table
    foreach (vecs[i]) begin
      @(negedge clk) drive(vecs[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d_op%0d", i, vecs[i].op), out, vecs[i].exp);
    end

    // Back-to-back: one op per cycle; result must be stable while the next op is presented
    foreach (b2b[i]) begin
      @(negedge clk) drive(b2b[i]);
      #1;
      if (i > 0) check($sformatf("b2b%0d_hold", i - 1), out, b2b[i-1].exp);
      @(posedge clk); #1;
      check($sformatf("b2b%0d_op%0d", i, b2b[i].op), out, b2b[i].exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
